// File: rtl/jtopl_wrseq_pkg.sv
// Shared types and timing constants for the jtopl write sequencer.
package jtopl_wrseq_pkg;

  localparam int unsigned STATE_W       = 3;
  localparam int unsigned OPL_ADDR_WAIT = 12;
  localparam int unsigned OPL_DATA_WAIT = 84;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    AWR   = 3'd1,
    AWAIT = 3'd2,
    DWR   = 3'd3,
    DWAIT = 3'd4
  } state_e;

  // One queued register write: OPL register index plus value.
  typedef struct packed {
    logic [7:0] regi;
    logic [7:0] data;
  } wr_req_t;

endpackage

// File: rtl/jtopl_wrfifo.sv
// Synchronous show-ahead FIFO for pending register writes; runs on every clk edge.
module jtopl_wrfifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/jtopl_wrseq.sv
// Replays queued (register, data) writes onto the jtopl CPU port as
// address/data strobe pairs, inserting the chip's post-write waits in cen ticks.
module jtopl_wrseq
  import jtopl_wrseq_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WR_LEN    = 1,
  parameter int unsigned ADDR_WAIT = OPL_ADDR_WAIT,
  parameter int unsigned DATA_WAIT = OPL_DATA_WAIT,
  parameter int unsigned CNTW      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cen,
  input  logic                     req_valid,
  input  logic [7:0]               req_reg,
  input  logic [7:0]               req_data,
  output logic                     req_ready,
  output logic [7:0]               opl_din,
  output logic                     opl_addr,
  output logic                     opl_cs_n,
  output logic                     opl_wr_n,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam logic [CNTW-1:0] WR_LOAD   = CNTW'(WR_LEN - 1);
  localparam logic [CNTW-1:0] ADDR_LOAD = (ADDR_WAIT == 0) ? '0 : CNTW'(ADDR_WAIT - 1);
  localparam logic [CNTW-1:0] DATA_LOAD = (DATA_WAIT == 0) ? '0 : CNTW'(DATA_WAIT - 1);

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  wr_req_t         cur_q, cur_d;
  logic [7:0]      din_q, din_d;
  logic            addr_q, addr_d;
  logic            cs_n_q, cs_n_d;
  logic            wr_n_q, wr_n_d;

  wr_req_t         fifo_head;
  wr_req_t         fifo_wdata;
  logic            fifo_pop_c;
  logic            fifo_full, fifo_empty;
  logic            next_write;

  assign req_ready  = ~fifo_full & ~rst;
  assign fifo_wdata = '{regi: req_reg, data: req_data};

  jtopl_wrfifo #(
    .DEPTH (DEPTH),
    .W     ($bits(wr_req_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid & req_ready),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop_c),
    .rdata_o (fifo_head),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sequencer: everything advances only on cen ticks; pin values follow the next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    din_d      = din_q;
    addr_d     = addr_q;
    cs_n_d     = cs_n_q;
    wr_n_d     = wr_n_q;
    fifo_pop_c = 1'b0;
    next_write = 1'b0;

    if (cen) begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop_c = 1'b1;
            cur_d      = fifo_head;
            cnt_d      = WR_LOAD;
            state_d    = AWR;
          end
        end
        AWR: begin
          if (cnt_q == '0) begin
            if (ADDR_WAIT != 0) begin
              state_d = AWAIT;
              cnt_d   = ADDR_LOAD;
            end else begin
              state_d = DWR;
              cnt_d   = WR_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CNTW'(1);
          end
        end
        AWAIT: begin
          if (cnt_q == '0) begin
            state_d = DWR;
            cnt_d   = WR_LOAD;
          end else begin
            cnt_d = cnt_q - CNTW'(1);
          end
        end
        DWR: begin
          if (cnt_q == '0) begin
            if (DATA_WAIT != 0) begin
              state_d = DWAIT;
              cnt_d   = DATA_LOAD;
            end else begin
              next_write = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CNTW'(1);
          end
        end
        DWAIT: begin
          if (cnt_q == '0) next_write = 1'b1;
          else             cnt_d = cnt_q - CNTW'(1);
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      // Chain straight into the next queued write without an idle tick.
      if (next_write) begin
        if (!fifo_empty) begin
          fifo_pop_c = 1'b1;
          cur_d      = fifo_head;
          cnt_d      = WR_LOAD;
          state_d    = AWR;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      cs_n_d = 1'b1;
      wr_n_d = 1'b1;
      unique case (state_d)
        AWR: begin
          cs_n_d = 1'b0;
          wr_n_d = 1'b0;
          addr_d = 1'b0;
          din_d  = cur_d.regi;
        end
        DWR: begin
          cs_n_d = 1'b0;
          wr_n_d = 1'b0;
          addr_d = 1'b1;
          din_d  = cur_d.data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      din_q   <= '0;
      addr_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
    end
  end

  assign opl_din  = din_q;
  assign opl_addr = addr_q;
  assign opl_cs_n = cs_n_q;
  assign opl_wr_n = wr_n_q;
  assign busy     = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_jtopl_wrseq.sv
// Directed bench for jtopl_wrseq: strobe timing, burst chaining, cen division, reset abort.
module tb_jtopl_wrseq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_reg = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic       req_ready;
  logic [7:0] opl_din;
  logic       opl_addr, opl_cs_n, opl_wr_n, busy;
  logic [2:0] level;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cen_div = 0;
  int div_cnt = 0;

  int         st_start[$];
  int         st_len[$];
  logic       st_addr[$];
  logic [7:0] st_din[$];
  int         busy_fall = -1;
  logic       prev_s = 1'b0;
  logic       prev_busy = 1'b0;

  logic [7:0] exp_r[$];
  logic [7:0] exp_d[$];
  logic [7:0] got_r[$];
  logic [7:0] got_d[$];

  jtopl_wrseq dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .req_valid (req_valid),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .req_ready (req_ready),
    .opl_din   (opl_din),
    .opl_addr  (opl_addr),
    .opl_cs_n  (opl_cs_n),
    .opl_wr_n  (opl_wr_n),
    .busy      (busy),
    .level     (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // cen is either always high or high one edge in four
  always @(negedge clk) begin
    if (cen_div == 0) begin
      cen = 1'b1;
    end else begin
      cen = (div_cnt == 3);
      div_cnt = (div_cnt + 1) % 4;
    end
  end

  // Bus monitor: records each strobe (start cycle, length, port, value)
  always @(negedge clk) begin
    logic s;
    s = !opl_cs_n && !opl_wr_n;
    if (s && !prev_s) begin
      st_start.push_back(cyc);
      st_len.push_back(1);
      st_addr.push_back(opl_addr);
      st_din.push_back(opl_din);
    end else if (s && prev_s) begin
      st_len[st_len.size()-1] = st_len[st_len.size()-1] + 1;
    end
    if (!busy && prev_busy) busy_fall = cyc;
    prev_s = s;
    prev_busy = busy;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    st_start.delete();
    st_len.delete();
    st_addr.delete();
    st_din.delete();
    exp_r.delete();
    exp_d.delete();
    busy_fall = -1;
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] d, output int k, output int waits);
    waits = 0;
    req_valid = 1'b1;
    req_reg = r;
    req_data = d;
    while (!req_ready && waits < 2000) begin
      tick();
      waits++;
    end
    tick();
    k = cyc;
    req_valid = 1'b0;
    exp_r.push_back(r);
    exp_d.push_back(d);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  // Decode strobes into (reg, data) pairs, as the chip would latch them.
  task automatic check_pairs(input string tag);
    logic [7:0] r;
    r = 8'h00;
    got_r.delete();
    got_d.delete();
    for (int i = 0; i < st_addr.size(); i++) begin
      if (!st_addr[i]) r = st_din[i];
      else begin
        got_r.push_back(r);
        got_d.push_back(st_din[i]);
      end
    end
    check({tag, "_count"}, 32'(got_r.size()), 32'(exp_r.size()));
    for (int i = 0; i < exp_r.size() && i < got_r.size(); i++) begin
      check({tag, "_reg"}, 32'(got_r[i]), 32'(exp_r[i]));
      check({tag, "_data"}, 32'(got_d[i]), 32'(exp_d[i]));
    end
  endtask

  initial begin
    int k, w, e;

    // Reset held with a pending request: nothing may be accepted
    req_valid = 1'b1;
    req_reg = 8'h55;
    req_data = 8'haa;
    tick(); tick(); tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_cs_n", 32'(opl_cs_n), 32'd1);
    check("rst_wr_n", 32'(opl_wr_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_din", 32'(opl_din), 32'd0);
    check("rst_addr", 32'(opl_addr), 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_level", 32'(level), 32'd0);

    // Single write at full cen rate
    clear_mon();
    push(8'h20, 8'h21, k, w);
    wait_idle("single_timeout", 300);
    check("single_nstrobe", 32'(st_start.size()), 32'd2);
    if (st_start.size() >= 2) begin
      check("single_latency", 32'(st_start[0]), 32'(k + 1));
      check("single_a_port", 32'(st_addr[0]), 32'd0);
      check("single_a_din", 32'(st_din[0]), 32'h20);
      check("single_a_len", 32'(st_len[0]), 32'd1);
      check("single_gap", 32'(st_start[1] - st_start[0]), 32'd13);
      check("single_d_port", 32'(st_addr[1]), 32'd1);
      check("single_d_din", 32'(st_din[1]), 32'h21);
      check("single_d_len", 32'(st_len[1]), 32'd1);
      check("single_busy_fall", 32'(busy_fall - st_start[0]), 32'd98);
    end

    // Burst of six into a four-deep FIFO
    clear_mon();
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i), 8'hc0 + 8'(i), k, w);
    check("burst_full_level", 32'(level), 32'd4);
    check("burst_full_ready", 32'(req_ready), 32'd0);
    push(8'h35, 8'hc5, k, w);
    check("burst_push6_waited", 32'(w > 0), 32'd1);
    wait_idle("burst_timeout", 1000);
    check_pairs("burst");
    if (st_start.size() == 12)
      for (int i = 0; i < 5; i++)
        check("burst_spacing", 32'(st_start[2*i+2] - st_start[2*i]), 32'd98);

    // cen high one edge in four
    cen_div = 1;
    div_cnt = 0;
    tick();
    clear_mon();
    push(8'h40, 8'h41, k, w);
    check("div_accept0", 32'(w), 32'd0);
    push(8'h42, 8'h43, k, w);
    check("div_accept1", 32'(w), 32'd0);
    wait_idle("div_timeout", 1500);
    check_pairs("div");
    if (st_start.size() == 4) begin
      for (int i = 0; i < 4; i++) check("div_strobe_len", 32'(st_len[i]), 32'd4);
      check("div_gap", 32'(st_start[1] - st_start[0]), 32'd52);
      check("div_spacing", 32'(st_start[2] - st_start[0]), 32'd392);
    end
    cen_div = 0;
    tick();

    // Reset during the address wait of the first of three writes
    clear_mon();
    push(8'h50, 8'h51, k, w);
    push(8'h52, 8'h53, k, w);
    push(8'h54, 8'h55, k, w);
    tick(); tick();
    check("abort_in_await", 32'(opl_cs_n), 32'd1);
    check("abort_pre_level", 32'(level), 32'd2);
    rst = 1'b1;
    tick();
    check("abort_cs_n", 32'(opl_cs_n), 32'd1);
    check("abort_wr_n", 32'(opl_wr_n), 32'd1);
    check("abort_level", 32'(level), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("abort_ready_after", 32'(req_ready), 32'd1);
    for (int i = 0; i < 150; i++) tick();
    check("abort_nstrobe", 32'(st_start.size()), 32'd1);
    check("abort_busy_after", 32'(busy), 32'd0);

    // Push lands on the same edge the FIFO pops at the end of DWAIT
    clear_mon();
    push(8'h60, 8'h61, k, w);
    push(8'h62, 8'h63, k, w);
    push(8'h64, 8'h65, k, w);
    if (st_start.size() >= 1) begin
      e = st_start[0] + 98;
      while (cyc < e - 1) tick();
      check("simul_pre_level", 32'(level), 32'd2);
      push(8'h66, 8'h67, k, w);
      check("simul_edge", 32'(k), 32'(e));
      check("simul_post_level", 32'(level), 32'd2);
    end else begin
      check("simul_first_strobe", 32'(st_start.size()), 32'd1);
    end
    wait_idle("simul_timeout", 1000);
    check_pairs("simul");
    if (st_start.size() >= 3) check("simul_chain_start", 32'(st_start[2]), 32'(e));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
